l2_host_req_arb: RTL and testbench
==================================

# l2_host_req_arb

Round-robin arbiter sharing one host request port among `nstrm` L2 stream pointers, with response routing back by stream tag. Sits between the per-stream L2 pointer blocks (their host request/response interfaces) and the host interface. Registers the winning request, tags it with its stream index, and limits total outstanding host requests with a credit counter. Routes each host response to the owning stream.

## Interface
Parameters:
- `nstrm`, 8: number of stream pointers arbitrated.
- `addr_width`, 64: host address width in bits.
- `sid_width`, `$clog2(nstrm)`: stream tag width.
- `max_outst`, 32: maximum in-flight host requests (all streams).
- `outst_width`, `$clog2(max_outst+1)`: credit counter width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_req_v`  in  nstrm  per-stream request valid.
- `i_req_r`  out  nstrm  per-stream request ready.
- `i_req_ea`  in  nstrm*addr_width  per-stream EA, stream s at bits [s*addr_width +: addr_width].
- `o_req_v`  out  1  host request valid.
- `o_req_r`  in  1  host request ready.
- `o_req_ea`  out  addr_width  host request EA.
- `o_req_tag`  out  sid_width  originating stream index.
- `i_rsp_v`  in  1  host response valid.
- `i_rsp_r`  out  1  host response ready.
- `i_rsp_tag`  in  sid_width  stream index of the response.
- `o_rsp_v`  out  nstrm  per-stream response valid (one-hot or zero).
- `o_rsp_r`  in  nstrm  per-stream response ready.
- `o_outst`  out  outst_width  current in-flight request count.

## Operation
- Request grant: `can_load = ~o_req_v | o_req_r`; `credit_ok = (o_outst + 0) < max_outst`. When `can_load & credit_ok`, the grant goes to the first asserted `i_req_v` after the round-robin pointer `rr`, searching cyclically from `rr+1`. Exactly one `i_req_r[g]` is high, and only for the granted stream. All other `i_req_r` bits are 0.
- Grant handshake (`i_req_v[g] & i_req_r[g]`) loads the output register: `o_req_v<=1`, `o_req_ea<=i_req_ea[g]`, `o_req_tag<=g`, `rr<=g`.
- If `o_req_r` is high and nothing is granted, `o_req_v<=0`. Otherwise the register holds its contents; `o_req_ea` and `o_req_tag` are stable while `o_req_v & ~o_req_r`.
- Credit: `o_outst` increments on a grant handshake and decrements on a response handshake (`i_rsp_v & i_rsp_r`). When both occur in the same cycle, `o_outst` is unchanged. At `o_outst == max_outst`, all `i_req_r` are 0; responses still drain.
- Response routing (combinational): `o_rsp_v[s] = i_rsp_v & (i_rsp_tag == s)`; `i_rsp_r = o_rsp_r[i_rsp_tag]`. A tag ≥ `nstrm` is accepted and dropped (`i_rsp_r=1`), and the credit is still returned.
- A response handshake with `o_outst == 0` is a protocol violation: the counter holds at 0 and a simulation assertion fires.
- Stream requests are never reordered within a stream. Response order is as delivered by the host.

## Timing
- Reset values (reset low): `o_req_v=0`, `o_req_ea=0`, `o_req_tag=0`, `o_outst=0`, `rr=nstrm-1`, so stream 0 wins first. All outputs derived from these are 0.
- Latency: grant cycle N gives `o_req_v` at N+1. Back-to-back grants every cycle while `o_req_r=1` and credit is available. There is no bubble on `o_req_r` high.
- `i_req_r` depends combinationally on `i_req_v`, `o_req_r`, `o_outst`, and `rr`. Stream pointers must not make `i_req_v` depend on `i_req_r`.
- Response path is zero-latency combinational. `o_outst` updates one cycle after the handshake.
- Reset asserted mid-operation clears the output register and credits immediately. Downstream in-flight responses after reset return credits only if `o_outst>0`.

## Configuration
- `L2_HOST_REQ_ARB_PERF_EN` defined adds two outputs:
  - `o_perf_req`: 32-bit count of host request handshakes.
  - `o_perf_stall`: 32-bit count of cycles with any `i_req_v` high but no grant.
  - Both saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent. Arbitration behaviour is identical.

## Structure
- Shared package `l2_pkg`: `sid_t` stream-index typedef, `max_outst` default, and the perf counter width constant (32).
- One sub-module, `l2_rr_arb`: a parameterised `nstrm`-way round-robin grant (request vector, pointer, enable → one-hot grant plus encoded index). The rest is the output register, credit counter, and response demux at top level.

## Test plan
- Reset, then all 8 streams assert with EA 0x1000*s and `o_req_r=1` → `o_req_tag` sequence 0,1,…,7,0 on consecutive cycles, first `o_req_v` one cycle after reset release.
- Stream 3 only valid, `o_req_r=0` for 5 cycles → `o_req_v=1`, `o_req_ea`/`o_req_tag=3` held stable, `i_req_r[3]=0` until `o_req_r` rises.
- `max_outst=4`, no responses, all streams valid → exactly 4 handshakes, `o_outst=4`, all `i_req_r=0`. One response then allows exactly one more grant.
- Grant and response in the same cycle at `o_outst=2` → `o_outst` stays 2.
- `i_rsp_v=1`, `i_rsp_tag=5`, `o_rsp_r[5]=0` → `o_rsp_v=8'b0010_0000`, `i_rsp_r=0`, `o_outst` unchanged. Raising `o_rsp_r[5]` decrements it.
- With `L2_HOST_REQ_ARB_PERF_EN`, 10 handshakes plus 3 credit-blocked cycles → `o_perf_req=10`, `o_perf_stall=3`.

Source files
------------

// File: rtl/l2_pkg.sv
// Shared types and constants for the L2 stream-pointer host request path.
package l2_pkg;

   localparam int nstrm_default     = 8;
   localparam int max_outst_default = 32;
   localparam int perf_width        = 32;

   typedef logic [$clog2(nstrm_default)-1:0] sid_t;

endpackage

// File: rtl/l2_rr_arb.sv
// Parameterised nstrm-way round-robin grant: searches cyclically from ptr+1,
// producing a one-hot grant, its encoded index and an any-grant flag.
module l2_rr_arb
   import l2_pkg::*;
#(
   parameter int nstrm     = nstrm_default,
   parameter int sid_width = $clog2(nstrm)
)(
   input  logic [nstrm-1:0]     req,
   input  logic [sid_width-1:0] ptr,
   input  logic                 en,
   output logic [nstrm-1:0]     gnt,
   output logic [sid_width-1:0] gnt_idx,
   output logic                 gnt_any
);

   localparam logic [sid_width:0] nstrm_w = (sid_width+1)'(nstrm);

   logic [sid_width:0]   sum;
   logic [sid_width-1:0] idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      sum     = '0;
      idx     = '0;
      // Offsets 1..nstrm visit every stream once, ending on the pointer itself.
      for (int k = 1; k <= nstrm; k++) begin
         sum = {1'b0, ptr} + (sid_width+1)'(k);
         idx = sid_width'((sum >= nstrm_w) ? (sum - nstrm_w) : sum);
         if (en && !gnt_any && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
            gnt_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/l2_host_req_arb.sv
// Round-robin host request arbiter with credit limit and response demux by tag.
// Define L2_HOST_REQ_ARB_PERF_EN to add saturating request/stall perf counters.
module l2_host_req_arb
   import l2_pkg::*;
#(
   parameter int nstrm       = nstrm_default,
   parameter int addr_width  = 64,
   parameter int sid_width   = $clog2(nstrm),
   parameter int max_outst   = max_outst_default,
   parameter int outst_width = $clog2(max_outst+1)
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic [nstrm-1:0]            i_req_v,
   output logic [nstrm-1:0]            i_req_r,
   input  logic [nstrm*addr_width-1:0] i_req_ea,
   output logic                        o_req_v,
   input  logic                        o_req_r,
   output logic [addr_width-1:0]       o_req_ea,
   output logic [sid_width-1:0]        o_req_tag,
   input  logic                        i_rsp_v,
   output logic                        i_rsp_r,
   input  logic [sid_width-1:0]        i_rsp_tag,
   output logic [nstrm-1:0]            o_rsp_v,
   input  logic [nstrm-1:0]            o_rsp_r,
   output logic [outst_width-1:0]      o_outst
`ifdef L2_HOST_REQ_ARB_PERF_EN
   ,
   output logic [perf_width-1:0]       o_perf_req,
   output logic [perf_width-1:0]       o_perf_stall
`endif
);

   localparam logic [outst_width-1:0] max_outst_w = outst_width'(max_outst);
   localparam logic [sid_width:0]     nstrm_w     = (sid_width+1)'(nstrm);

   logic [sid_width-1:0] rr;
   logic [nstrm-1:0]     gnt;
   logic [sid_width-1:0] gnt_idx;
   logic                 gnt_any;
   logic                 can_load;
   logic                 credit_ok;
   logic                 tag_ok;
   logic                 rsp_hs;
   logic                 rsp_dec;

   assign can_load  = ~o_req_v | o_req_r;
   assign credit_ok = o_outst < max_outst_w;

   l2_rr_arb #(
      .nstrm     (nstrm),
      .sid_width (sid_width)
   ) u_arb (
      .req     (i_req_v),
      .ptr     (rr),
      .en      (can_load & credit_ok),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   // The arbiter only grants asserted requests, so a grant is a handshake.
   assign i_req_r = gnt;

   generate
      for (genvar gi = 0; gi < nstrm; gi++) begin : g_rsp
         assign o_rsp_v[gi] = i_rsp_v & (i_rsp_tag == sid_width'(gi));
      end
   endgenerate

   // Tags with no owning stream are swallowed but still return their credit.
   assign tag_ok  = {1'b0, i_rsp_tag} < nstrm_w;
   assign i_rsp_r = tag_ok ? o_rsp_r[i_rsp_tag] : 1'b1;
   assign rsp_hs  = i_rsp_v & i_rsp_r;
   assign rsp_dec = rsp_hs & (o_outst != '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_req_v   <= 1'b0;
         o_req_ea  <= '0;
         o_req_tag <= '0;
         rr        <= sid_width'(nstrm - 1);
      end else if (gnt_any) begin
         o_req_v   <= 1'b1;
         o_req_ea  <= i_req_ea[gnt_idx*addr_width +: addr_width];
         o_req_tag <= gnt_idx;
         rr        <= gnt_idx;
      end else if (o_req_r) begin
         o_req_v   <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_outst <= '0;
      end else begin
         case ({gnt_any, rsp_dec})
            2'b10:   o_outst <= o_outst + 1'b1;
            2'b01:   o_outst <= o_outst - 1'b1;
            default: o_outst <= o_outst;
         endcase
      end
   end

   rsp_underflow: assert property (@(posedge clk) disable iff (!reset)
      !(rsp_hs && (o_outst == '0)));

`ifdef L2_HOST_REQ_ARB_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_perf_req   <= '0;
         o_perf_stall <= '0;
      end else begin
         if (o_req_v && o_req_r && (o_perf_req != '1))
            o_perf_req <= o_perf_req + 1'b1;
         if ((|i_req_v) && !gnt_any && (o_perf_stall != '1))
            o_perf_stall <= o_perf_stall + 1'b1;
      end
   end
`else
   // Perf counters are not built; arbitration is unaffected.
`endif

endmodule

// File: tb/tb_l2_host_req_arb.sv
// Scoreboard bench for l2_host_req_arb: reference model of the arbitration
// rules, per-stream request queues, and a separate host-side monitor.
module tb_l2_host_req_arb;
   import l2_pkg::*;

   localparam int NS = 8;
   localparam int AW = 64;
   localparam int SW = 3;
   localparam int MO = 4;
   localparam int OW = 3;

   logic             clk;
   logic             reset;
   logic [NS-1:0]    i_req_v;
   logic [NS-1:0]    i_req_r;
   logic [NS*AW-1:0] i_req_ea;
   logic             o_req_v;
   logic             o_req_r;
   logic [AW-1:0]    o_req_ea;
   logic [SW-1:0]    o_req_tag;
   logic             i_rsp_v;
   logic             i_rsp_r;
   logic [SW-1:0]    i_rsp_tag;
   logic [NS-1:0]    o_rsp_v;
   logic [NS-1:0]    o_rsp_r;
   logic [OW-1:0]    o_outst;
`ifdef L2_HOST_REQ_ARB_PERF_EN
   logic [31:0]      o_perf_req;
   logic [31:0]      o_perf_stall;
`endif

   l2_host_req_arb #(
      .nstrm      (NS),
      .addr_width (AW),
      .max_outst  (MO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .i_req_v   (i_req_v),
      .i_req_r   (i_req_r),
      .i_req_ea  (i_req_ea),
      .o_req_v   (o_req_v),
      .o_req_r   (o_req_r),
      .o_req_ea  (o_req_ea),
      .o_req_tag (o_req_tag),
      .i_rsp_v   (i_rsp_v),
      .i_rsp_r   (i_rsp_r),
      .i_rsp_tag (i_rsp_tag),
      .o_rsp_v   (o_rsp_v),
      .o_rsp_r   (o_rsp_r),
      .o_outst   (o_outst)
`ifdef L2_HOST_REQ_ARB_PERF_EN
      ,
      .o_perf_req   (o_perf_req),
      .o_perf_stall (o_perf_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] ea;
      sid_t          tag;
   } exp_t;

   exp_t          exp_q[$];
   logic [AW-1:0] sbuf[NS][256];
   int            head[NS];
   int            cnt[NS];

   // Reference model state: last winner, register occupancy, credits in use.
   int m_rr;
   bit m_occ;
   int m_outst;
   int m_perf_req;
   int m_perf_stall;

   int checks;
   int passes;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic push_ea(input int s, input logic [AW-1:0] ea);
      if (cnt[s] < 256) begin
         sbuf[s][(head[s] + cnt[s]) % 256] = ea;
         cnt[s]++;
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_rr = NS - 1;
      m_occ = 1'b0;
      m_outst = 0;
      m_perf_req = 0;
      m_perf_stall = 0;
   endtask

   // One clock cycle: drive at the falling edge, check combinational and
   // registered outputs against the model, then advance the model.
   task automatic step(input logic [NS-1:0] gate, input logic rdy, input logic rv,
                       input logic [SW-1:0] rt, input logic [NS-1:0] rmask);
      logic [NS-1:0] exp_gnt;
      logic [NS-1:0] exp_rspv;
      logic [NS-1:0] one;
      int g;
      int s;
      exp_t e;
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
         i_req_v[i] = gate[i] && (cnt[i] > 0);
         i_req_ea[i*AW +: AW] = (cnt[i] > 0) ? sbuf[i][head[i]] : {$urandom, $urandom};
      end
      o_req_r   = rdy;
      i_rsp_v   = rv && (m_outst > 0);
      i_rsp_tag = rt;
      o_rsp_r   = rmask;
      #1;
      g = -1;
      if ((!m_occ || rdy) && (m_outst < MO)) begin
         for (int k = 1; k <= NS; k++) begin
            s = (m_rr + k) % NS;
            if (g < 0 && i_req_v[s]) g = s;
         end
      end
      exp_gnt = '0;
      if (g >= 0) exp_gnt[g] = 1'b1;
      one = 1;
      exp_rspv = i_rsp_v ? (one << rt) : '0;
      chk("i_req_r", i_req_r, exp_gnt);
      chk("o_req_v", o_req_v, m_occ);
      chk("o_outst", o_outst, m_outst);
      chk("o_rsp_v", o_rsp_v, exp_rspv);
      chk("i_rsp_r", i_rsp_r, rmask[rt]);
`ifdef L2_HOST_REQ_ARB_PERF_EN
      chk("o_perf_req", o_perf_req, m_perf_req);
      chk("o_perf_stall", o_perf_stall, m_perf_stall);
      if (m_occ && rdy) m_perf_req++;
      if ((|i_req_v) && g < 0) m_perf_stall++;
`endif
      if (g >= 0) begin
         e.ea  = sbuf[g][head[g]];
         e.tag = sid_t'(g);
         exp_q.push_back(e);
         head[g] = (head[g] + 1) % 256;
         cnt[g]--;
         m_rr = g;
         m_occ = 1'b1;
         m_outst++;
      end else if (rdy) begin
         m_occ = 1'b0;
      end
      if (i_rsp_v && rmask[rt]) m_outst--;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && (m_outst > 0 || m_occ); i++)
         step('0, 1'b1, 1'b1, SW'($urandom_range(0, NS-1)), '1);
   endtask

   task automatic mid_reset();
      @(negedge clk);
      i_req_v = '0;
      o_req_r = 1'b0;
      i_rsp_v = 1'b0;
      reset   = 1'b0;
      #1;
      chk("rst_o_req_v", o_req_v, 0);
      chk("rst_o_outst", o_outst, 0);
      chk("rst_o_req_ea", o_req_ea, 0);
      chk("rst_o_req_tag", o_req_tag, 0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Host-side monitor: every cycle the register is valid it must hold the
   // oldest expected request; the entry retires on the host handshake.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (reset && o_req_v) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL o_req_unexpected: got ea %0h tag %0d expected none", o_req_ea, o_req_tag);
            end else begin
               chk("o_req_ea", o_req_ea, exp_q[0].ea);
               chk("o_req_tag", o_req_tag, exp_q[0].tag);
               if (o_req_r) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      checks = 0;
      passes = 0;
      for (int s = 0; s < NS; s++) begin
         head[s] = 0;
         cnt[s] = 0;
      end
      model_reset();
      reset = 1'b0;
      i_req_v = '0;
      i_req_ea = '0;
      o_req_r = 1'b0;
      i_rsp_v = 1'b0;
      i_rsp_tag = '0;
      o_rsp_r = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_o_req_v", o_req_v, 0);
      chk("reset_o_req_ea", o_req_ea, 0);
      chk("reset_o_req_tag", o_req_tag, 0);
      chk("reset_o_outst", o_outst, 0);
      chk("reset_i_req_r", i_req_r, 0);
      chk("reset_o_rsp_v", o_rsp_v, 0);
      @(negedge clk);
      reset = 1'b1;

      // All streams valid, host always ready: tags 0..7 then 0 again.
      for (int s = 0; s < NS; s++) push_ea(s, 64'h1000 * s);
      push_ea(0, 64'h8000);
      for (int i = 0; i < 10; i++) step('1, 1'b1, 1'b1, SW'(i), '1);
      drain();

      // Stream 3 alone while the host stalls for five cycles.
      push_ea(3, 64'hABC0);
      push_ea(3, 64'hABC8);
      for (int i = 0; i < 6; i++) step(8'h08, 1'b0, 1'b0, '0, '1);
      for (int i = 0; i < 3; i++) step(8'h08, 1'b1, 1'b0, '0, '1);
      drain();

      // Credit exhaustion, then one response frees exactly one grant.
      for (int s = 0; s < NS; s++) begin
         push_ea(s, 64'h2000_0000 + s);
         push_ea(s, 64'h3000_0000 + s);
      end
      for (int i = 0; i < 8; i++) step('1, 1'b1, 1'b0, '0, '1);
      step('1, 1'b1, 1'b1, 3'd2, '1);
      for (int i = 0; i < 4; i++) step('1, 1'b1, 1'b0, '0, '1);

      // Down to two credits, then grant and response in the same cycle.
      step('0, 1'b1, 1'b1, 3'd1, '1);
      step('0, 1'b1, 1'b1, 3'd1, '1);
      step('1, 1'b1, 1'b1, 3'd4, '1);
      step('0, 1'b1, 1'b0, '0, '1);

      // Response to a stream that is not ready, then ready.
      step('0, 1'b1, 1'b1, 3'd5, 8'hDF);
      step('0, 1'b1, 1'b1, 3'd5, 8'hDF);
      step('0, 1'b1, 1'b1, 3'd5, '1);
      drain();

      for (int i = 0; i < 600; i++) begin
         for (int s = 0; s < NS; s++)
            if ($urandom_range(0, 3) == 0 && cnt[s] < 200) push_ea(s, {$urandom, $urandom});
         if (i == 300) mid_reset();
         step(NS'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              SW'($urandom_range(0, NS-1)), ($urandom_range(0, 3) == 0) ? NS'($urandom) : '1);
      end
      drain();
      step('0, 1'b1, 1'b0, '0, '1);
      chk("exp_q_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
